main_control_fsm: RTL

Multicycle main control unit of the MIPS datapath. It sits directly upstream of the ALU control decoder: it sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath mux selects and write enables. It also drives the 2-bit ALU operation class consumed by the ALU control decoder, and takes that decoder's break indication back to halt the core.

---
 rtl/main_control_fsm.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
//
// Multicycle main control unit for the MIPS datapath. Each instruction is
// walked through fetch, decode, execute, memory and write-back states. The
// block drives the datapath mux selects and write enables, and the 2-bit ALU
// operation class used by the ALU control decoder. The decoder's break
// indication is fed back here so that the core can be halted.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset (state FETCH, outputs 0)
//   opcode      in   IR[31:26], meaningful from DECODE onward
//   break_in    in   break from ALU control decoder, looked at only in DECODE
//   zero        in   ALU zero flag, looked at only in BRANCH
//   pc_write    out  PC load enable, already qualified by branch condition
//   i_or_d      out  memory address select (0 PC, 1 ALUOut)
//   mem_write   out  memory write strobe
//   ir_write    out  instruction register load
//   mdr_write   out  memory data register load
//   reg_write   out  register file write
//   reg_dst     out  destination select (0 rt, 1 rd)
//   mem_to_reg  out  write-back source (00 ALUOut, 01 MDR, 10 imm<<16)
//   alu_src_a   out  ALU A select (0 PC, 1 rs)
//   alu_src_b   out  ALU B select (00 rt, 01 4, 10 sext imm, 11 sext imm<<2)
//   alu_op      out  ALU class (00 add, 01 sub, 10 use funct)
//   pc_source   out  PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   halted      out  core stopped by break, held until reset
//   illegal_op  out  unknown opcode trapped, held until reset
//   state       out  current state encoding for debug
//
// Build option
//   ILLEGAL_OP_TRAP_EN : when defined, an unknown opcode in DECODE sends the
//                        machine to TRAP and raises illegal_op. When left
//                        undefined, an unknown opcode simply returns to FETCH
//                        (a 3-cycle NOP) and illegal_op stays 0.
// ---------------------------------------------------------------------------
module main_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       break_in,
    input  logic       zero,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       halted,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_MEM_ADDR   = 4'd3,
        S_LW_READ    = 4'd4,
        S_LW_WAIT    = 4'd5,
        S_LW_WB      = 4'd6,
        S_SW_WRITE   = 4'd7,
        S_R_EXEC     = 4'd8,
        S_R_WB       = 4'd9,
        S_BRANCH     = 4'd10,
        S_JUMP       = 4'd11,
        S_LUI_WB     = 4'd12,
        S_HALT       = 4'd13,
        S_TRAP       = 4'd14
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_J   = 6'h02;

    state_t r_state;
    state_t w_nextState;

    // State register. Reset puts the machine back at FETCH at once, which
    // abandons whatever instruction was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. In DECODE a break on an R-type opcode wins over
    // normal dispatch; a break seen with any other opcode is ignored.
    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:      w_nextState = S_FETCH_WAIT;
            S_FETCH_WAIT: w_nextState = S_DECODE;
            S_DECODE: begin
                if (break_in && (opcode == OP_R)) begin
                    w_nextState = S_HALT;
                end else begin
                    case (opcode)
                        OP_R:           w_nextState = S_R_EXEC;
                        OP_LW, OP_SW:   w_nextState = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: w_nextState = S_BRANCH;
                        OP_J:           w_nextState = S_JUMP;
                        OP_LUI:         w_nextState = S_LUI_WB;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:        w_nextState = S_TRAP;
`else
                        default:        w_nextState = S_FETCH;
`endif
                    endcase
                end
            end
            S_MEM_ADDR:   w_nextState = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
            S_LW_READ:    w_nextState = S_LW_WAIT;
            S_LW_WAIT:    w_nextState = S_LW_WB;
            S_LW_WB:      w_nextState = S_FETCH;
            S_SW_WRITE:   w_nextState = S_FETCH;
            S_R_EXEC:     w_nextState = S_R_WB;
            S_R_WB:       w_nextState = S_FETCH;
            S_BRANCH:     w_nextState = S_FETCH;
            S_JUMP:       w_nextState = S_FETCH;
            S_LUI_WB:     w_nextState = S_FETCH;
            S_HALT:       w_nextState = S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:       w_nextState = S_TRAP;
`endif
            default:      w_nextState = S_FETCH;
        endcase
    end

    // Output decode from the registered state. While reset is held every
    // output is forced low, which matters because the reset state (FETCH)
    // would otherwise assert pc_write. In BRANCH, pc_write follows zero for
    // beq and its inverse for bne; opcode bit 0 tells them apart.
    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        halted     = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                end
                S_FETCH_WAIT: begin
                    ir_write = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_LW_READ: begin
                    i_or_d = 1'b1;
                end
                S_LW_WAIT: begin
                    i_or_d    = 1'b1;
                    mdr_write = 1'b1;
                end
                S_LW_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                S_SW_WRITE: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_write  = opcode[0] ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                S_LUI_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b10;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                S_TRAP: begin
                    illegal_op = 1'b1;
                end
`endif
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    assign state = r_state;

endmodule
